// File: rtl/freq_bcd_display.sv
// Binary-to-BCD converter (double-dabble) with a multiplexed 7-segment scanner.
// Define FREQ_BCD_LZB_EN to blank leading zero digits on the display.
module freq_bcd_display #(
  parameter int DATA_W   = 30,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_vld,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_vld,
  output logic                  overflow,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_led
);

  localparam int NB = (3 * DATA_W) / 10 + 1;
  localparam int NP = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   op;
  logic [4*NB-1:0]     acc;
  logic [CW-1:0]       bit_cnt;

  logic [DATA_W-1:0]   op_nxt;
  logic [4*NB-1:0]     adj;
  logic [4*NB-1:0]     acc_nxt;
  logic [4*NP-1:0]     acc_pad;
  logic [4*DIGITS-1:0] res;
  logic                ovf;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NB; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    acc_nxt = {adj[4*NB-2:0], op[DATA_W-1]};
    op_nxt  = {op[DATA_W-2:0], 1'b0};
  end

  // Pad to the wider of accumulator/display so both loops index safely.
  always_comb begin
    acc_pad = '0;
    acc_pad[4*NB-1:0] = acc;
    ovf = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (i >= DIGITS && acc_pad[i*4 +: 4] != 4'd0)
        ovf = 1'b1;
    end
    res = '0;
    for (int i = 0; i < DIGITS; i++)
      res[i*4 +: 4] = ovf ? 4'd9 : acc_pad[i*4 +: 4];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      op       <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      bcd_out  <= '0;
      bcd_vld  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bcd_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (data_vld) begin
            op      <= data_in;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= acc_nxt;
          op      <= op_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W - 1))
            state <= DONE;
        end
        DONE: begin
          bcd_out  <= res;
          overflow <= ovf;
          bcd_vld  <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [3:0]    cur_nib;
  logic          blank;

  assign cur_nib = bcd_out[{idx, 2'b00} +: 4];

`ifdef FREQ_BCD_LZB_EN
  logic [DIGITS-1:0] lz;
  logic              hi_zero;

  // lz[i]: nibble i and everything above it are zero.
  always_comb begin
    hi_zero = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (bcd_out[i*4 +: 4] == 4'd0);
      lz[i] = hi_zero;
    end
  end

  assign blank = (idx != '0) && lz[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_sel  <= '1;
      seg_led  <= 8'hFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        if (idx == IW'(DIGITS - 1))
          idx <= '0;
        else
          idx <= idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_sel <= ~(DIGITS'(1) << idx);
      seg_led <= {~dp_in[idx], blank ? 7'h7F : seg7(cur_nib)};
    end
  end

endmodule

// File: tb/tb_freq_bcd_display.sv
// Self-checking bench for freq_bcd_display: vector table, random
// conversions against a decimal model, abort/ignore sequences, scan checks.
module tb_freq_bcd_display;

  localparam int DW = 30;
  localparam int DG = 8;
  localparam int SD = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_vld;
  logic          busy;
  logic [31:0]   bcd_out;
  logic          bcd_vld;
  logic          overflow;
  logic [DG-1:0] dp_in;
  logic [DG-1:0] seg_sel;
  logic [7:0]    seg_led;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  freq_bcd_display #(
    .DATA_W(DW),
    .DIGITS(DG),
    .SCAN_DIV(SD)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .data_in(data_in),
    .data_vld(data_vld),
    .busy(busy),
    .bcd_out(bcd_out),
    .bcd_vld(bcd_vld),
    .overflow(overflow),
    .dp_in(dp_in),
    .seg_sel(seg_sel),
    .seg_led(seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic void ref_conv(input longint unsigned v,
                                   output logic [31:0] b,
                                   output logic o);
    longint unsigned t;
    t = v;
    b = '0;
    o = 1'b0;
    if (v > 64'd99999999) begin
      b = 32'h99999999;
      o = 1'b1;
    end else begin
      for (int i = 0; i < DG; i++) begin
        b[i*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
  endfunction

  function automatic logic [7:0] exp_seg(input int i, input logic [31:0] b,
                                         input logic [7:0] dp);
    logic [6:0] tab [0:9];
    logic [3:0] n;
    logic [6:0] s;
    logic [31:0] hi;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    n = b[i*4 +: 4];
    s = (n > 4'd9) ? 7'h7F : tab[n];
    hi = b >> (4 * i);
`ifdef FREQ_BCD_LZB_EN
    if (i > 0 && hi == 32'd0) s = 7'h7F;
`endif
    return {~dp[i], s};
  endfunction

  always @(negedge clk) if (bcd_vld) pulses++;

  // Scan cadence: every change of seg_sel is one position up, SD cycles apart.
  int         mon_cyc;
  int         mon_last;
  logic [7:0] mon_prev;
  always @(negedge clk) begin
    if (rst) begin
      mon_cyc  = 0;
      mon_last = 0;
      mon_prev = 8'hFF;
    end else begin
      mon_cyc++;
      if (seg_sel != mon_prev) begin
        if (mon_prev != 8'hFF) begin
          chk("scan_step", seg_sel, {mon_prev[6:0], mon_prev[7]});
          chk("scan_period", 64'(mon_cyc - mon_last), 64'(SD));
        end
        mon_last = mon_cyc;
        mon_prev = seg_sel;
      end
    end
  end

  task automatic convert(input logic [DW-1:0] v, input string nm,
                         output logic [31:0] b, output logic o);
    int lat;
    data_in  = v;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    chk({nm, "_busy_start"}, busy, 1);
    lat = 0;
    while (!bcd_vld && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, DW + 1);
    chk({nm, "_busy_end"}, busy, 0);
    b = bcd_out;
    o = overflow;
    @(negedge clk);
    chk({nm, "_vld_pulse"}, bcd_vld, 0);
  endtask

  task automatic scan_check(input string nm, input logic [31:0] b,
                            input logic [7:0] dp, input int n);
    int d;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      d = -1;
      for (int k = 0; k < DG; k++)
        if (seg_sel == ~(8'd1 << k)) d = k;
      if (d < 0) begin
        chk({nm, "_sel_onehot"}, seg_sel, 8'hFE);
      end else begin
        chk({nm, "_led"}, seg_led, exp_seg(d, b, dp));
      end
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [31:0]   bcd;
    logic          ovf;
  } vec_t;

  vec_t          vecs [9];
  logic [31:0]   got_b;
  logic          got_o;
  logic [31:0]   exp_b;
  logic          exp_o;
  logic [DW-1:0] rv;
  logic [7:0]    rdp;
  int            p0;

  initial begin
    vecs[0] = '{30'd123456,    32'h00123456, 1'b0};
    vecs[1] = '{30'h3FFFFFFF,  32'h99999999, 1'b1};
    vecs[2] = '{30'd0,         32'h00000000, 1'b0};
    vecs[3] = '{30'd99999999,  32'h99999999, 1'b0};
    vecs[4] = '{30'd100000000, 32'h99999999, 1'b1};
    vecs[5] = '{30'd42,        32'h00000042, 1'b0};
    vecs[6] = '{30'd705,       32'h00000705, 1'b0};
    vecs[7] = '{30'd10000000,  32'h10000000, 1'b0};
    vecs[8] = '{30'd909090,    32'h00909090, 1'b0};

    rst      = 1'b1;
    data_in  = '0;
    data_vld = 1'b0;
    dp_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_vld", bcd_vld, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sel", seg_sel, 8'hFF);
    chk("rst_led", seg_led, 8'hFF);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].din, "vec", got_b, got_o);
      chk("vec_bcd", got_b, vecs[i].bcd);
      chk("vec_ovf", got_o, vecs[i].ovf);
    end

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        rv = DW'($urandom_range(0, 99999999));
      else
        rv = DW'($urandom);
      ref_conv(64'(rv), exp_b, exp_o);
      convert(rv, "rnd", got_b, got_o);
      chk("rnd_bcd", got_b, exp_b);
      chk("rnd_ovf", got_o, exp_o);
    end

    // A request arriving mid-conversion is dropped.
    p0 = pulses;
    data_in  = 30'd42;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    chk("ign_busy", busy, 1);
    repeat (5) @(negedge clk);
    data_in  = 30'd999;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    data_in  = '0;
    for (int t = 0; t < 60 && !bcd_vld; t++) @(negedge clk);
    chk("ign_bcd", bcd_out, 32'h42);
    chk("ign_ovf", overflow, 0);
    repeat (50) @(negedge clk);
    chk("ign_pulses", pulses - p0, 1);
    chk("ign_idle", busy, 0);

    // Reset during SHIFT aborts with no result pulse.
    data_in  = 30'd123;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    repeat (10) @(negedge clk);
    p0 = pulses;
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_vld", bcd_vld, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_pulses", pulses - p0, 0);
    chk("abort_hold", bcd_out, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    convert(30'd7, "post_rst", got_b, got_o);
    chk("post_rst_bcd", got_b, 32'h7);

    convert(30'd705, "scan705", got_b, got_o);
    dp_in = 8'h00;
    repeat (2) @(negedge clk);
    scan_check("scan705", 32'h00000705, 8'h00, 40);

    dp_in = 8'h01;
    convert(30'd0, "scan0", got_b, got_o);
    repeat (2) @(negedge clk);
    scan_check("scan0", 32'h0, 8'h01, 40);

    for (int i = 0; i < 3; i++) begin
      rv  = DW'($urandom);
      if (i > 0) rv = DW'($urandom_range(0, 99999));
      rdp = 8'($urandom);
      ref_conv(64'(rv), exp_b, exp_o);
      dp_in = rdp;
      convert(rv, "scan_rnd", got_b, got_o);
      chk("scan_rnd_bcd", got_b, exp_b);
      repeat (2) @(negedge clk);
      scan_check("scan_rnd", exp_b, rdp, 40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/freq_bcd_display.md
FREQ_BCD_DISPLAY -- requirements
Module: freq_bcd_display

Interface
REQ-001 The block SHALL have parameter DATA_W, default 30, meaning the binary input width; legal range 4..64.
REQ-002 The block SHALL have parameter DIGITS, default 8, meaning the number of displayed decimal digits and 7-segment positions; legal range 1..16.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, meaning the sys_clk cycles per digit scan slot; minimum 2.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, DATA_W bits: unsigned measured frequency.
REQ-007 The block SHALL have port data_vld, input, 1 bit: request to convert data_in.
REQ-008 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port bcd_out, output, 4*DIGITS bits: latched BCD result, with digit 0 (least significant) in [3:0].
REQ-010 The block SHALL have port bcd_vld, output, 1 bit: one-cycle pulse on each bcd_out update.
REQ-011 The block SHALL have port overflow, output, 1 bit: the last result exceeded DIGITS digits.
REQ-012 The block SHALL have port dp_in, input, DIGITS bits: decimal point per digit, active-high.
REQ-013 The block SHALL have port seg_sel, output, DIGITS bits: one-hot active-low digit enable, with bit i = digit i.
REQ-014 The block SHALL have port seg_led, output, 8 bits: active-low {dp,g,f,e,d,c,b,a}.

Function
REQ-015 The conversion FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-016 IDLE→SHIFT SHALL occur when data_vld=1; on that edge data_in is captured, busy becomes 1 and the BCD accumulator is cleared.
REQ-017 SHIFT SHALL run exactly DATA_W cycles; each cycle it adds 3 to every accumulator nibble ≥5, then shifts {accumulator,operand} left by 1 (double-dabble).
REQ-018 The accumulator SHALL hold NBCD = floor(3*DATA_W/10)+1 nibbles.
REQ-019 DONE SHALL last 1 cycle; on its edge bcd_out and overflow load, bcd_vld pulses for 1 cycle, busy returns to 0, and the FSM returns to IDLE.
REQ-020 Latency SHALL be fixed: if data_vld is sampled at edge k, bcd_vld=1 in the cycle after edge k+DATA_W+1.
REQ-021 data_vld SHALL be ignored whenever busy=1; there is no queueing, and the in-flight result is unaffected.
REQ-022 Overflow SHALL be set when any accumulator nibble above DIGITS-1 is nonzero; bcd_out then saturates to all 9s and overflow=1; otherwise overflow=0.
REQ-023 If NBCD≤DIGITS, overflow SHALL be constant 0 and the upper bcd_out nibbles SHALL be zero-filled.
REQ-024 bcd_out and overflow SHALL hold between updates.
REQ-025 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index advances by 1, wrapping DIGITS-1→0.
REQ-026 seg_sel and seg_led SHALL be registered with one cycle of latency from the index: seg_sel=~(1<<idx), seg_led[7]=~dp_in[idx], and seg_led[6:0] decodes bcd_out nibble idx.
REQ-027 The active-low decode with dp off SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-028 A nibble >9 SHALL decode as blank, with seg_led[6:0]=7F.
REQ-029 A conversion SHALL NOT stall or alter scanning; the display shows the previous bcd_out until bcd_vld.

Reset
REQ-030 While sys_rst=1, the block SHALL force the FSM to IDLE, busy=0, bcd_out=0, bcd_vld=0, overflow=0, scan counter=0, idx=0, seg_sel=all ones and seg_led=FF.
REQ-031 A reset asserted mid-SHIFT or mid-DONE SHALL abort the conversion with no bcd_vld pulse.
REQ-032 After reset release, the first data_vld=1 SHALL be accepted on the first clock edge.

Configuration
REQ-033 When macro FREQ_BCD_LZB_EN is defined, any digit i>0 whose nibble and all higher nibbles are 0 SHALL display blank segments (7F) while dp still follows dp_in; digit 0 is never blanked.
REQ-034 When FREQ_BCD_LZB_EN is undefined, all digits SHALL be decoded, including leading zeros; bcd_out is identical in both builds.

Verification
REQ-035 Defaults, data_in=123456, data_vld one cycle → busy for 31 cycles, bcd_vld one cycle after edge k+31, bcd_out=32'h00123456, overflow=0.
REQ-036 Defaults, data_in=30'h3FFFFFFF (1073741823) → bcd_out=32'h99999999, overflow=1.
REQ-037 data_in=42 accepted, then data_vld with 999 at SHIFT cycle 5 → single bcd_vld, bcd_out=32'h00000042, and 999 never converted.
REQ-038 sys_rst pulsed at SHIFT cycle 10 → busy=0 and bcd_out=0 immediately, no bcd_vld; a following data_in=7 yields bcd_out=32'h00000007.
REQ-039 SCAN_DIV=4, bcd_out=32'h00000705, dp_in=0, FREQ_BCD_LZB_EN defined → seg_sel steps FE,FD,FB,F7,... every 4 cycles, seg_led=92,C0,F8 then FF for digits 3..7; with the macro undefined, digits 3..7 show C0.
REQ-040 data_in=0, dp_in=8'h01, FREQ_BCD_LZB_EN defined → digit 0 seg_led=40 and digits 1..7 show FF.
